// File: rtl/aes_block_loader.sv
// Assembles four 32-bit words into 128-bit key or plaintext blocks and hands
// each plaintext block, paired with the committed key, to the round-0 stage.
//
// state   | meaning
// COLLECT | accepting words into the shadow register (o_ready=1)
// EMIT    | o_tx_en pulse; o_state/o_round_key carry the new block
// HOLD    | MIN_GAP idle cycles before the next group may start
module aes_block_loader #(
   parameter int unsigned MIN_GAP = 0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [31:0]  i_word,
   input  logic         i_is_key,
   input  logic         i_flush,
   output logic         o_tx_en,
   output logic [127:0] o_state,
   output logic [127:0] o_round_key,
   output logic         o_key_valid,
   output logic         o_err
);

   typedef enum logic [1:0] {COLLECT, EMIT, HOLD} state_t;

   localparam logic [3:0] GAP_LOAD = 4'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

   state_t         state;
   logic [1:0]     cnt;
   logic           grp_key;
   logic [127:0]   shadow;
   logic [127:0]   key;
   logic [3:0]     gap_cnt;
   logic [127:0]   full_blk;

   // The 4th word completes the block in the same cycle it is accepted.
   assign full_blk = {shadow[127:32], i_word};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= COLLECT;
         cnt         <= 2'd0;
         grp_key     <= 1'b0;
         shadow      <= '0;
         key         <= '0;
         gap_cnt     <= 4'd0;
         o_ready     <= 1'b1;
         o_tx_en     <= 1'b0;
         o_state     <= '0;
         o_round_key <= '0;
         o_key_valid <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (i_flush) begin
                  cnt    <= 2'd0;
                  shadow <= '0;
               end else if (i_valid) begin
                  cnt <= cnt + 2'd1;
                  case (cnt)
                     2'd0:    shadow[127:96] <= i_word;
                     2'd1:    shadow[95:64]  <= i_word;
                     2'd2:    shadow[63:32]  <= i_word;
                     default: shadow[31:0]   <= i_word;
                  endcase
                  if (cnt == 2'd0) begin
                     grp_key <= i_is_key;
                  end
                  if (cnt == 2'd3) begin
                     if (grp_key) begin
                        key         <= full_blk;
                        o_key_valid <= 1'b1;
                     end else if (o_key_valid) begin
                        o_state     <= full_blk;
                        o_round_key <= key;
                        o_tx_en     <= 1'b1;
                        o_ready     <= 1'b0;
                        state       <= EMIT;
                     end else begin
                        o_err <= 1'b1;
                     end
                  end
               end
            end
            EMIT: begin
               o_tx_en <= 1'b0;
               if (MIN_GAP == 0) begin
                  o_ready <= 1'b1;
                  state   <= COLLECT;
               end else begin
                  gap_cnt <= GAP_LOAD;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (gap_cnt == 4'd0) begin
                  o_ready <= 1'b1;
                  state   <= COLLECT;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: begin
               o_tx_en <= 1'b0;
               o_ready <= 1'b1;
               state   <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: one instance with no gap, one with MIN_GAP=2.
module tb_aes_block_loader;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         i_valid = 1'b0;
   logic [31:0]  i_word = '0;
   logic         i_is_key = 1'b0;
   logic         i_flush = 1'b0;

   logic         rdy0, tx0, kv0, err0;
   logic [127:0] st0, rk0;
   logic         rdy2, tx2, kv2, err2;
   logic [127:0] st2, rk2;

   int errors = 0;
   int checks = 0;
   int np0 = 0;
   int np2 = 0;
   int cyc = 0;
   int t_last = 0;
   int t_prev = 0;
   int base;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] D1 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] D3 = 128'hcafef00d11112222333344445555aaaa;

   aes_block_loader #(.MIN_GAP(0)) u_dut (
      .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(rdy0),
      .i_word(i_word), .i_is_key(i_is_key), .i_flush(i_flush), .o_tx_en(tx0),
      .o_state(st0), .o_round_key(rk0), .o_key_valid(kv0), .o_err(err0)
   );

   aes_block_loader #(.MIN_GAP(2)) u_gap (
      .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(rdy2),
      .i_word(i_word), .i_is_key(i_is_key), .i_flush(i_flush), .o_tx_en(tx2),
      .o_state(st2), .o_round_key(rk2), .o_key_valid(kv2), .o_err(err2)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (tx0) np0 <= np0 + 1;
      if (tx2) begin
         np2    <= np2 + 1;
         t_prev <= t_last;
         t_last <= cyc;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one word and waits until the selected instance accepts it; i_valid stays high.
   task automatic send(input logic [31:0] w, input logic k, input int which);
      int n = 0;
      i_valid  = 1'b1;
      i_word   = w;
      i_is_key = k;
      while (((which == 0) ? rdy0 : rdy2) !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("ready_timeout", 128'(n), 128'(0));
      tick();
   endtask

   task automatic send_group(input logic [127:0] blk, input logic k, input int which);
      for (int i = 0; i < 4; i++) send(blk[127-32*i -: 32], k, which);
      i_valid = 1'b0;
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      i_flush = 1'b0;
      reset   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      tick();
      chk("rst_ready", 128'(rdy0), 128'(1));
      chk("rst_tx_en", 128'(tx0), 128'(0));
      chk("rst_key_valid", 128'(kv0), 128'(0));
      chk("rst_err", 128'(err0), 128'(0));
      chk("rst_state", st0, '0);
      chk("rst_round_key", rk0, '0);
      reset = 1'b0;
      tick();

      // data with no key committed
      base = np0;
      send_group(D1, 1'b0, 0);
      chk("nokey_tx_en", 128'(tx0), 128'(0));
      chk("nokey_err", 128'(err0), 128'(1));
      repeat (20) tick();
      chk("nokey_err_sticky", 128'(err0), 128'(1));
      chk("nokey_no_pulse", 128'(np0 - base), 128'(0));
      chk("nokey_key_valid", 128'(kv0), 128'(0));

      // key then data
      do_reset();
      chk("err_cleared", 128'(err0), 128'(0));
      send_group(K1, 1'b1, 0);
      chk("key_valid", 128'(kv0), 128'(1));
      chk("key_no_pulse", 128'(tx0), 128'(0));
      chk("key_ready", 128'(rdy0), 128'(1));
      base = np0;
      send_group(D1, 1'b0, 0);
      chk("vec_tx_en", 128'(tx0), 128'(1));
      chk("vec_state", st0, D1);
      chk("vec_round_key", rk0, K1);
      chk("vec_ready_low", 128'(rdy0), 128'(0));
      tick();
      chk("vec_tx_one_cycle", 128'(tx0), 128'(0));
      chk("vec_ready_back", 128'(rdy0), 128'(1));
      chk("vec_pulse_count", 128'(np0 - base), 128'(1));

      // flush beats a simultaneous accept
      base = np0;
      send(32'h11111111, 1'b0, 0);
      send(32'h22222222, 1'b0, 0);
      i_flush = 1'b1;
      i_word  = 32'hdeadbeef;
      tick();
      i_flush = 1'b0;
      i_valid = 1'b0;
      tick();
      chk("flush_no_pulse", 128'(np0 - base), 128'(0));
      chk("flush_key_kept", 128'(kv0), 128'(1));
      send_group(D2, 1'b0, 0);
      chk("flush_tx_en", 128'(tx0), 128'(1));
      chk("flush_state", st0, D2);
      tick();
      chk("flush_single_pulse", 128'(np0 - base), 128'(1));

      // key replacement only takes effect on the next emit
      send(K2[127:96], 1'b1, 0);
      send(K2[95:64], 1'b0, 0);
      send(K2[63:32], 1'b0, 0);
      send(K2[31:0], 1'b0, 0);
      i_valid = 1'b0;
      chk("k2_no_pulse", 128'(tx0), 128'(0));
      chk("k2_round_key_old", rk0, K1);
      chk("k2_state_held", st0, D2);
      repeat (3) tick();
      chk("k2_round_key_still_old", rk0, K1);
      send_group(D3, 1'b0, 0);
      chk("k2_tx_en", 128'(tx0), 128'(1));
      chk("k2_round_key_new", rk0, K2);
      chk("k2_state", st0, D3);
      tick();

      // reset mid-group
      do_reset();
      send_group(K1, 1'b1, 0);
      send(D1[127:96], 1'b0, 0);
      send(D1[95:64], 1'b0, 0);
      send(D1[63:32], 1'b0, 0);
      i_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midrst_key_valid", 128'(kv0), 128'(0));
      chk("midrst_round_key", rk0, '0);
      tick();
      reset = 1'b0;
      base = np0;
      repeat (6) tick();
      chk("midrst_no_pulse", 128'(np0 - base), 128'(0));
      send_group(K1, 1'b1, 0);
      send_group(D1, 1'b0, 0);
      chk("midrst_tx_en", 128'(tx0), 128'(1));
      chk("midrst_state", st0, D1);
      chk("midrst_round_key", rk0, K1);
      tick();

      // MIN_GAP=2 with continuous valid
      do_reset();
      send_group(K1, 1'b1, 1);
      base = np2;
      for (int g = 0; g < 2; g++) begin
         for (int w = 0; w < 4; w++) begin
            if (g == 0) send(D1[127-32*w -: 32], 1'b0, 1);
            else        send(D2[127-32*w -: 32], 1'b0, 1);
         end
         chk("gap_tx_en", 128'(tx2), 128'(1));
         chk("gap_state", st2, (g == 0) ? D1 : D2);
         chk("gap_ready_0", 128'(rdy2), 128'(0));
         tick();
         chk("gap_ready_1", 128'(rdy2), 128'(0));
         chk("gap_tx_width", 128'(tx2), 128'(0));
         tick();
         chk("gap_ready_2", 128'(rdy2), 128'(0));
         tick();
         chk("gap_ready_3", 128'(rdy2), 128'(1));
      end
      i_valid = 1'b0;
      chk("gap_pulse_count", 128'(np2 - base), 128'(2));
      chk("gap_pulse_spacing", 128'(t_last - t_prev), 128'(7));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
